// File: rtl/bcu_pkg.sv
// bcu_pkg: opcodes, flag indices and return-stack entry type for branch_ctrl_unit
package bcu_pkg;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JC   = 5'b11100;
  localparam logic [4:0] OP_JNC  = 5'b11101;
  localparam logic [4:0] OP_JZ   = 5'b11110;
  localparam logic [4:0] OP_JNZ  = 5'b11111;
  localparam logic [4:0] OP_RET  = 5'b10000;
  localparam logic [4:0] OP_CALL = 5'b11001;
  localparam logic [4:0] OP_RETI = 5'b10001;
  localparam int CARRY = 0;
  localparam int ZERO  = 1;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_FLAG_W = 4;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_FLAG_W-1:0] flags;
  } stack_entry_t;
endpackage

// File: rtl/bcu_ret_stack.sv
// bcu_ret_stack: LIFO return stack; overflowing pushes are dropped, err_o pulses on bad push/pop
module bcu_ret_stack #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = empty_o ? '0 : mem_q[IW'(cnt_q - CW'(1))];
  assign err_o   = (push_i & full_o) | (pop_i & empty_o);
  assign cnt_d   = (push_i & !full_o) ? cnt_q + CW'(1) : (pop_i & !empty_o) ? cnt_q - CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // Storage is not reset: a cleared count already discards every entry.
  always_ff @(posedge clk)
    if (push_i && !full_o) mem_q[IW'(cnt_q)] <= din_i;
endmodule

// File: rtl/branch_ctrl_unit.sv
// branch_ctrl_unit: PC redirect decision for jumps, CALL/RET and vectored nested interrupts
module branch_ctrl_unit
  import bcu_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                INS_W       = 20,
  parameter int                FLAG_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter int                NUM_IRQ     = 4,
  parameter logic [ADDR_W-1:0] IRQ_BASE    = 'hF0,
  parameter int                VEC_STRIDE  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INS_W-1:0]           ins,
  input  logic [FLAG_W-1:0]          flag_ex,
  input  logic [ADDR_W-1:0]          ret_addr,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       int_en,
  output logic                       pc_mux_sel,
  output logic [ADDR_W-1:0]          jmp_loc,
  output logic                       flush,
  output logic                       irq_ack,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  output logic [FLAG_W-1:0]          flag_restore,
  output logic                       flag_restore_vld,
  output logic                       stack_err
);
  localparam int IDW = $clog2(NUM_IRQ);
  localparam int EW  = ADDR_W + FLAG_W;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [FLAG_W-1:0] flags;
  } entry_t;
  entry_t             top_e, push_e;
  logic [4:0]         op;
  logic [ADDR_W-1:0]  tgt, vec;
  logic [NUM_IRQ-1:0] is_q, is_d, irq_oh, is_lo;
  logic [IDW-1:0]     id_q, id_d, irq_idx;
  logic               take_q, take_d, err_q, err_d;
  logic               dec_en, jmp_op, is_call, is_ret, is_reti, stk_op;
  logic               blocked, accept, push, pop, full, empty, stk_err;
  logic               unused_ins;
  assign op         = ins[INS_W-1 -: 5];
  assign tgt        = ins[ADDR_W-1:0];
  assign unused_ins = ^ins[INS_W-6:ADDR_W];
  // Decode is muted in reset and during the interrupt take cycle.
  assign dec_en  = reset & !take_q;
  assign jmp_op  = dec_en & ((op == OP_JMP) | (op == OP_JC & flag_ex[CARRY]) | (op == OP_JNC & !flag_ex[CARRY])
                   | (op == OP_JZ & flag_ex[ZERO]) | (op == OP_JNZ & !flag_ex[ZERO]));
  assign is_call = dec_en & (op == OP_CALL);
  assign is_ret  = dec_en & (op == OP_RET);
  assign is_reti = dec_en & (op == OP_RETI);
  assign stk_op  = (op == OP_CALL) | (op == OP_RET) | (op == OP_RETI);
  always_comb begin
    irq_idx = '0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) if (irq[j]) irq_idx = IDW'(j);
  end
  // One-hot lowest set bits; a request is blocked by any in-service level at or above its priority.
  assign irq_oh  = irq & (~irq + NUM_IRQ'(1));
  assign is_lo   = is_q & (~is_q + NUM_IRQ'(1));
  assign blocked = |(is_q & (irq_oh | (irq_oh - NUM_IRQ'(1))));
  assign accept  = dec_en & int_en & (|irq) & !blocked & !full & !stk_op;
  assign push    = is_call | accept;
  assign pop     = is_ret | is_reti;
  assign push_e  = '{addr: ret_addr, flags: flag_ex};
  bcu_ret_stack #(.DW(EW), .DEPTH(STACK_DEPTH)) u_stack (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (push_e),
    .dout_o (top_e),
    .full_o (full),
    .empty_o(empty),
    .err_o  (stk_err)
  );
  assign vec              = IRQ_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(id_q);
  assign pc_mux_sel       = take_q | jmp_op | is_call | pop;
  assign flush            = pc_mux_sel;
  assign jmp_loc          = take_q ? vec : pop ? top_e.addr : (jmp_op | is_call) ? tgt : '0;
  assign irq_ack          = take_q;
  assign irq_id           = take_q ? id_q : '0;
  assign flag_restore_vld = is_reti & !empty;
  assign flag_restore     = flag_restore_vld ? top_e.flags : '0;
  assign stack_err        = err_q;
  assign take_d = accept;
  assign id_d   = accept ? irq_idx : id_q;
  assign is_d   = (is_q & ~(is_reti ? is_lo : '0)) | (accept ? irq_oh : '0);
  assign err_d  = err_q | stk_err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      take_q <= 1'b0;
      id_q   <= '0;
      is_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      take_q <= take_d;
      id_q   <= id_d;
      is_q   <= is_d;
      err_q  <= err_d;
    end
endmodule

// File: tb/tb_branch_ctrl_unit.sv
// tb_branch_ctrl_unit: scoreboard bench for branch_ctrl_unit jumps, return stack and interrupts
module tb_branch_ctrl_unit;
  import bcu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] ins = '0;
  logic [3:0]  flag_ex = '0;
  logic [7:0]  ret_addr = '0;
  logic [3:0]  irq = '0;
  logic        int_en = 1'b0;
  logic        pc_mux_sel, flush, irq_ack, flag_restore_vld, stack_err;
  logic [7:0]  jmp_loc;
  logic [1:0]  irq_id;
  logic [3:0]  flag_restore;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [19:0] ins;
    logic [3:0]  fl;
    logic [7:0]  ra;
    logic [3:0]  iq;
    logic        en;
    string       nm;
    logic [18:0] v;
  } step_t;
  typedef struct {
    string       nm;
    logic [18:0] v;
  } exp_t;
  step_t st[$];
  exp_t  sb[$];
  localparam logic [4:0] NOP = 5'b00000;
  branch_ctrl_unit dut (
    .clk(clk), .reset(reset), .ins(ins), .flag_ex(flag_ex), .ret_addr(ret_addr),
    .irq(irq), .int_en(int_en), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .flush(flush),
    .irq_ack(irq_ack), .irq_id(irq_id), .flag_restore(flag_restore),
    .flag_restore_vld(flag_restore_vld), .stack_err(stack_err)
  );
  always #5 clk = ~clk;
  function automatic logic [18:0] obs();
    return {pc_mux_sel, flush, jmp_loc, irq_ack, irq_id, flag_restore, flag_restore_vld, stack_err};
  endfunction
  function automatic logic [18:0] ex(input logic pc, input logic [7:0] j, input logic ack,
                                     input logic [1:0] id, input logic [3:0] fr, input logic frv, input logic er);
    return {pc, pc, j, ack, id, fr, frv, er};
  endfunction
  function automatic logic [18:0] jt(input logic [7:0] j, input logic er);
    return ex(1'b1, j, 1'b0, 2'd0, 4'h0, 1'b0, er);
  endfunction
  function automatic logic [18:0] nt(input logic er);
    return ex(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b0, er);
  endfunction
  task automatic add(input logic [4:0] op, input logic [7:0] tgt, input logic [3:0] fl, input logic [7:0] ra,
                     input logic [3:0] iq, input logic en, input string nm, input logic [18:0] v);
    st.push_back('{ins: {op, 7'h00, tgt}, fl: fl, ra: ra, iq: iq, en: en, nm: nm, v: v});
  endtask
  task automatic test_reset();
    exp_t e;
    ins = {OP_JMP, 7'h00, 8'h55};
    int_en = 1'b1;
    irq = 4'b0001;
    #3 reset = 1'b0;
    #1 sb.push_back('{"reset_outputs", nt(1'b0)});
    e = sb.pop_front();
    checks++;
    if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    checks++;
    if (dut.u_stack.cnt_q !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", dut.u_stack.cnt_q); end
    ins = '0; irq = '0; int_en = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_cond_jumps();
    step_t s; exp_t e;
    add(OP_JZ,   8'h3A, 4'b0010, 8'h00, 4'h0, 1'b0, "jz_taken", jt(8'h3A, 1'b0));
    add(OP_JZ,   8'h3A, 4'b0000, 8'h00, 4'h0, 1'b0, "jz_not", nt(1'b0));
    add(OP_JC,   8'h3A, 4'b0001, 8'h00, 4'h0, 1'b0, "jc_taken", jt(8'h3A, 1'b0));
    add(OP_JC,   8'h3A, 4'b0010, 8'h00, 4'h0, 1'b0, "jc_not", nt(1'b0));
    add(OP_JNC,  8'h3B, 4'b0010, 8'h00, 4'h0, 1'b0, "jnc_taken", jt(8'h3B, 1'b0));
    add(OP_JNC,  8'h3B, 4'b0001, 8'h00, 4'h0, 1'b0, "jnc_not", nt(1'b0));
    add(OP_JNZ,  8'h3C, 4'b0001, 8'h00, 4'h0, 1'b0, "jnz_taken", jt(8'h3C, 1'b0));
    add(OP_JNZ,  8'h3C, 4'b0010, 8'h00, 4'h0, 1'b0, "jnz_not", nt(1'b0));
    add(OP_JMP,  8'hFF, 4'b0000, 8'h00, 4'h0, 1'b0, "jmp", jt(8'hFF, 1'b0));
    add(5'b01010, 8'h12, 4'b1111, 8'h00, 4'h0, 1'b0, "other_opcode", nt(1'b0));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_call_ret();
    step_t s; exp_t e;
    add(OP_CALL, 8'h20, 4'h0, 8'h05, 4'h0, 1'b0, "call_20", jt(8'h20, 1'b0));
    add(OP_CALL, 8'h40, 4'h0, 8'h22, 4'h0, 1'b0, "call_40", jt(8'h40, 1'b0));
    add(OP_RET,  8'h99, 4'h0, 8'h00, 4'h0, 1'b0, "ret_inner", jt(8'h22, 1'b0));
    add(OP_RET,  8'h99, 4'h0, 8'h00, 4'h0, 1'b0, "ret_outer", jt(8'h05, 1'b0));
    add(NOP,     8'h00, 4'h0, 8'h00, 4'h0, 1'b0, "after_ret", nt(1'b0));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.u_stack.cnt_q !== 3'd0) begin failures++; $display("FAIL call_ret_count: got %0d expected 0", dut.u_stack.cnt_q); end
  endtask
  task automatic test_irq_take();
    step_t s; exp_t e;
    add(NOP,     8'h00, 4'b0011, 8'h11, 4'b0100, 1'b1, "irq2_sample", nt(1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "irq2_take", ex(1'b1, 8'hF4, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "take_clears", nt(1'b0));
    add(OP_RETI, 8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "reti_irq2", ex(1'b1, 8'h11, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0100, 1'b0, "irq_disabled", nt(1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "irq_not_latched", nt(1'b0));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_nesting();
    step_t s; exp_t e;
    add(NOP,     8'h00, 4'b0001, 8'h30, 4'b0100, 1'b1, "n_irq2_sample", nt(1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "n_irq2_take", ex(1'b1, 8'hF4, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0));
    add(NOP,     8'h00, 4'b0010, 8'h31, 4'b0101, 1'b1, "n_irq0_sample", nt(1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "n_irq0_take", ex(1'b1, 8'hF0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b1000, 1'b1, "n_irq3_masked", nt(1'b0));
    add(OP_RETI, 8'h00, 4'b0000, 8'h00, 4'b1000, 1'b1, "n_reti0", ex(1'b1, 8'h31, 1'b0, 2'd0, 4'b0010, 1'b1, 1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b1000, 1'b1, "n_irq3_still_masked", nt(1'b0));
    add(OP_RETI, 8'h00, 4'b0000, 8'h00, 4'b1000, 1'b1, "n_reti2", ex(1'b1, 8'h30, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0));
    add(NOP,     8'h00, 4'b0100, 8'h44, 4'b1000, 1'b1, "n_irq3_sample", nt(1'b0));
    add(NOP,     8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "n_irq3_take", ex(1'b1, 8'hF6, 1'b1, 2'd3, 4'h0, 1'b0, 1'b0));
    add(OP_RETI, 8'h00, 4'b0000, 8'h00, 4'b0000, 1'b1, "n_reti3", ex(1'b1, 8'h44, 1'b0, 2'd0, 4'b0100, 1'b1, 1'b0));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.u_stack.cnt_q !== 3'd0) begin failures++; $display("FAIL nest_count: got %0d expected 0", dut.u_stack.cnt_q); end
  endtask
  task automatic test_overflow();
    step_t s; exp_t e;
    for (int k = 0; k < 5; k++)
      add(OP_CALL, 8'(8'h60 + k), 4'h0, 8'(k + 1), 4'h0, 1'b0, $sformatf("ovf_call%0d", k), jt(8'(8'h60 + k), 1'b0));
    add(NOP, 8'h00, 4'h0, 8'h00, 4'b0001, 1'b1, "full_no_accept", nt(1'b1));
    add(NOP, 8'h00, 4'h0, 8'h00, 4'b0000, 1'b1, "full_no_take", nt(1'b1));
    for (int k = 0; k < 4; k++)
      add(OP_RET, 8'h00, 4'h0, 8'h00, 4'h0, 1'b0, $sformatf("ovf_ret%0d", k), jt(8'(4 - k), 1'b1));
    add(OP_RET,  8'h77, 4'h0, 8'h00, 4'h0, 1'b0, "ret_empty", jt(8'h00, 1'b1));
    add(OP_RETI, 8'h77, 4'h0, 8'h00, 4'h0, 1'b0, "reti_empty", jt(8'h00, 1'b1));
    add(NOP,     8'h00, 4'h0, 8'h00, 4'h0, 1'b0, "err_sticky", nt(1'b1));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid();
    step_t s; exp_t e;
    add(NOP, 8'h00, 4'h0, 8'h77, 4'b0010, 1'b1, "rm_irq1_sample", nt(1'b1));
    while (st.size() > 0) begin
      s = st.pop_front();
      ins = s.ins; flag_ex = s.fl; ret_addr = s.ra; irq = s.iq; int_en = s.en;
      sb.push_back('{s.nm, s.v});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
      @(posedge clk); #1;
    end
    irq = '0;
    sb.push_back('{"rm_take_pending", ex(1'b1, 8'hF2, 1'b1, 2'd1, 4'h0, 1'b0, 1'b1)});
    sb.push_back('{"rm_reset_now", nt(1'b0)});
    sb.push_back('{"rm_after_release", nt(1'b0)});
    e = sb.pop_front();
    checks++;
    if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    reset = 1'b0;
    #1 e = sb.pop_front();
    checks++;
    if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) e = sb.pop_front();
    checks++;
    if (obs() !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.nm, obs(), e.v); end
    checks++;
    if (dut.u_stack.cnt_q !== 3'd0) begin failures++; $display("FAIL rm_count: got %0d expected 0", dut.u_stack.cnt_q); end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_cond_jumps();
    test_call_ret();
    test_irq_take();
    test_nesting();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
